// File: rtl/pcpi_initiator.sv
// Core-side PCPI initiator: offers one instruction to the co-processors, then
// returns a single-cycle write-back, or a trap when no responder claims it in time.
module pcpi_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_insn,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic        flush,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_busy,
  input  logic        pcpi_ready,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_idx,
  output logic [31:0] wb_data,
  output logic        trap
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    TRAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [4:0]       rd_idx;
  logic             wr_ok;

  // Saturating increment: the counter parks at the limit instead of wrapping.
  assign cnt_next = (cnt_reg >= CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
  assign rd_idx   = pcpi_insn[11:7];
  assign wr_ok    = pcpi_wr && (rd_idx != 5'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      issue_ready <= 1'b1;
      pcpi_valid  <= 1'b0;
      pcpi_insn   <= '0;
      pcpi_rs1    <= '0;
      pcpi_rs2    <= '0;
      wb_valid    <= 1'b0;
      wb_en       <= 1'b0;
      wb_idx      <= '0;
      wb_data     <= '0;
      trap        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      trap     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue_valid) begin
            pcpi_insn   <= issue_insn;
            pcpi_rs1    <= issue_rs1;
            pcpi_rs2    <= issue_rs2;
            pcpi_valid  <= 1'b1;
            issue_ready <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          // Priority: flush, then ready, then busy, then timeout counting.
          if (flush) begin
            pcpi_valid  <= 1'b0;
            issue_ready <= 1'b1;
            state_reg   <= IDLE;
          end else if (pcpi_ready) begin
            pcpi_valid <= 1'b0;
            wb_valid   <= 1'b1;
            wb_idx     <= rd_idx;
            wb_en      <= wr_ok;
            wb_data    <= wr_ok ? pcpi_rd : 32'd0;
            state_reg  <= DONE;
          end else if (pcpi_busy) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_next;
            if (cnt_next >= CNT_MAX) begin
              pcpi_valid <= 1'b0;
              trap       <= 1'b1;
              wb_idx     <= rd_idx;
              wb_en      <= 1'b0;
              wb_data    <= 32'd0;
              state_reg  <= TRAP;
            end
          end
        end
        DONE, TRAP: begin
          wb_en       <= 1'b0;
          wb_idx      <= '0;
          wb_data     <= '0;
          issue_ready <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          pcpi_valid  <= 1'b0;
          issue_ready <= 1'b1;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcpi_initiator.sv
// Randomized scoreboard bench for pcpi_initiator: a per-transaction responder plan
// is resolved by a rule-level model into an expected outcome, checked by a monitor.
module tb_pcpi_initiator;

  localparam int TO = 16;
  localparam int NP = 120;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [31:0] issue_insn = '0;
  logic [31:0] issue_rs1 = '0;
  logic [31:0] issue_rs2 = '0;
  logic        flush = 1'b0;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        pcpi_busy = 1'b0;
  logic        pcpi_ready = 1'b0;
  logic        wb_valid;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        trap;

  pcpi_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_insn(issue_insn), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .flush(flush),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_trap;
    logic [4:0]  idx;
    logic        en;
    logic [31:0] data;
    int          vcycles;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          txn_id = 0;
  logic [31:0] cur_insn = '0, cur_rs1 = '0, cur_rs2 = '0;

  // Responder plan, indexed by WAIT cycle number (1 = first cycle pcpi_valid is high).
  bit          pb[NP+1];
  bit          pr[NP+1];
  bit          pf[NP+1];
  logic        pw[NP+1];
  logic [31:0] prd[NP+1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn=%0d actual=0x%0h required=0x%0h", name, txn_id, act, req);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i <= NP; i++) begin
      pb[i] = 0; pr[i] = 0; pf[i] = 0; pw[i] = 0; prd[i] = '0;
    end
  endtask

  // Outcome from the rules: flush first, then ready, busy resets the idle run,
  // and TO consecutive unclaimed cycles end in a trap. kind: 0 done, 1 trap, 2 flush.
  task automatic model(output int kind, output int e);
    int run;
    run = 0; kind = 3; e = NP;
    for (int i = 1; i <= NP; i++) begin
      if (pf[i]) begin kind = 2; e = i; break; end
      if (pr[i]) begin kind = 0; e = i; break; end
      if (pb[i]) run = 0;
      else begin
        run++;
        if (run >= TO) begin kind = 1; e = i; break; end
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    int kind, e, w;
    exp_t x;
    model(kind, e);
    w = 0;
    @(negedge clk);
    while (!issue_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!issue_ready) begin
      chk("issue_ready_timeout", {31'd0, issue_ready}, 32'd1);
      return;
    end
    if (kind < 2) begin
      x.is_trap = (kind == 1);
      x.idx     = insn[11:7];
      x.en      = (kind == 0) && pw[e] && (insn[11:7] != 5'd0);
      x.data    = x.en ? prd[e] : 32'd0;
      x.vcycles = e;
      q.push_back(x);
    end else begin
      $display("txn %0d: insn=0x%08h flushed at wait cycle %0d", txn_id, insn, e);
    end
    cur_insn = insn; cur_rs1 = rs1; cur_rs2 = rs2;
    issue_insn = insn; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    issue_insn = $urandom; issue_rs1 = $urandom; issue_rs2 = $urandom;
    for (int i = 1; i <= e; i++) begin
      pcpi_busy = pb[i]; pcpi_ready = pr[i]; flush = pf[i];
      pcpi_wr = pr[i] ? pw[i] : 1'($urandom_range(0, 1));
      pcpi_rd = pr[i] ? prd[i] : $urandom;
      @(posedge clk); #1;
    end
    pcpi_busy = 0; pcpi_ready = 0; flush = 0; pcpi_wr = 0;
    // Spurious responder activity outside WAIT must produce nothing.
    repeat (3) begin
      pcpi_ready = 1'($urandom_range(0, 1));
      pcpi_busy  = 1'($urandom_range(0, 1));
      pcpi_wr    = 1'($urandom_range(0, 1));
      flush      = 1'($urandom_range(0, 1));
      pcpi_rd    = $urandom;
      @(posedge clk); #1;
    end
    pcpi_busy = 0; pcpi_ready = 0; flush = 0; pcpi_wr = 0;
    txn_id++;
  endtask

  // Monitor: checks operands while offered, and pops the scoreboard on each event.
  initial begin : monitor
    bit pv_prev;
    int vcnt;
    exp_t x;
    pv_prev = 0; vcnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pv_prev = 0;
      end else begin
        if (pcpi_valid) begin
          vcnt = pv_prev ? vcnt + 1 : 1;
          chk("pcpi_insn", pcpi_insn, cur_insn);
          chk("pcpi_rs1", pcpi_rs1, cur_rs1);
          chk("pcpi_rs2", pcpi_rs2, cur_rs2);
          chk("issue_ready_in_wait", {31'd0, issue_ready}, 32'd0);
        end
        pv_prev = pcpi_valid;
        if (wb_valid || trap) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event txn=%0d actual wb_valid=%0b trap=%0b required none",
                     txn_id, wb_valid, trap);
          end else begin
            x = q.pop_front();
            $display("txn %0d: %s idx=%0d en=%0b data=0x%08h valid_cycles=%0d",
                     txn_id, x.is_trap ? "trap" : "writeback", wb_idx, wb_en, wb_data, vcnt);
            chk("trap", {31'd0, trap}, {31'd0, x.is_trap});
            chk("wb_valid", {31'd0, wb_valid}, {31'd0, !x.is_trap});
            chk("wb_idx", {27'd0, wb_idx}, {27'd0, x.idx});
            chk("valid_cycles", vcnt, x.vcycles);
            if (!x.is_trap) begin
              chk("wb_en", {31'd0, wb_en}, {31'd0, x.en});
              chk("wb_data", wb_data, x.data);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] insn;
    int m, r, f;
    repeat (3) @(negedge clk);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("rst_pcpi_insn", pcpi_insn, 32'd0);
    chk("rst_wb", {26'd0, wb_valid, wb_en, wb_idx}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // mul x5,x6,x7: busy three cycles, then ready with 42
    clear_plan();
    pb[1] = 1; pb[2] = 1; pb[3] = 1; pr[4] = 1; pw[4] = 1; prd[4] = 32'd42;
    run_txn(32'h027302B3, 32'd7, 32'd6);
    // div: immediate ready, all-ones result
    clear_plan();
    pr[1] = 1; pw[1] = 1; prd[1] = 32'hFFFFFFFF;
    run_txn(32'h027342B3, 32'd1, 32'd0);
    // unclaimed custom instruction traps after TO cycles
    clear_plan();
    run_txn(32'h0000000B, 32'd3, 32'd4);
    // long busy keeps the timeout away
    clear_plan();
    for (int i = 1; i <= 40; i++) pb[i] = 1;
    pr[41] = 1; pw[41] = 1; prd[41] = 32'h1234_5678;
    run_txn(32'h02A5_8633, $urandom, $urandom);
    // ready on the timeout cycle wins
    clear_plan();
    pr[TO] = 1; pw[TO] = 1; prd[TO] = 32'hCAFE_0001;
    run_txn(32'h02B6_06B3, $urandom, $urandom);
    // flush beats ready in the same cycle, then a normal instruction
    clear_plan();
    pf[2] = 1; pr[2] = 1; pw[2] = 1; prd[2] = 32'hDEAD;
    run_txn(32'h027302B3, 32'd9, 32'd9);
    clear_plan();
    pr[2] = 1; pw[2] = 1; prd[2] = 32'h0000_BEEF;
    run_txn(32'h0273_0733, 32'd5, 32'd5);
    // write to x0 is suppressed
    clear_plan();
    pr[3] = 1; pw[3] = 1; prd[3] = 32'h5555_AAAA;
    run_txn(32'h0273_0033, 32'd1, 32'd2);

    for (int t = 0; t < 25; t++) begin
      clear_plan();
      m = $urandom_range(0, 3);
      for (int i = 1; i <= 60; i++) pb[i] = ($urandom_range(0, 3) == 0);
      if (m == 1) for (int i = 11; i <= 60; i++) pb[i] = 0;
      r = $urandom_range(1, 30);
      f = $urandom_range(1, 10);
      if (m == 0 || m == 3) begin
        pr[r] = 1; pw[r] = 1'($urandom_range(0, 1)); prd[r] = $urandom;
      end
      if (m == 2) begin
        pf[f] = 1; pr[f] = 1'($urandom_range(0, 1)); pw[f] = 1; prd[f] = $urandom;
      end
      insn = $urandom;
      if ($urandom_range(0, 3) == 0) insn[11:7] = 5'd0;
      run_txn(insn, $urandom, $urandom);
    end

    // asynchronous reset in WAIT, then a stray ready in IDLE
    clear_plan();
    cur_insn = 32'h0273_02B3; cur_rs1 = 32'd11; cur_rs2 = 32'd12;
    @(negedge clk);
    issue_insn = cur_insn; issue_rs1 = cur_rs1; issue_rs2 = cur_rs2; issue_valid = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    pcpi_busy = 1'b1;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    chk("arst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("arst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("arst_pcpi_insn", pcpi_insn, 32'd0);
    chk("arst_outputs", {25'd0, wb_valid, wb_en, wb_idx, trap}, 32'd0);
    pcpi_busy = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("txn %0d: reset during wait, stray ready in idle", txn_id);
    chk("post_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("post_rst_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
